// File: rtl/spi_pkg.sv
// Shared constants for the SPI register bridge: command codes, FSM encodings,
// the read-timeout fill pattern and default bus widths.
package spi_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned TO_CYC_DEF = 255;

    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_READ  = 4'h2;

    localparam logic [15:0] RD_TIMEOUT_PATTERN = 16'hDEAD;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_WAIT = 3'd1;
    localparam logic [2:0] ST_WR_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_HOLD = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Single-beat req/ack register bus between the bridge (master) and the
// accelerator register file (slave).
interface spi_reg_bridge_if import spi_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/spi_bus_timer.sv
// Bus transaction watchdog: load restarts the count, clear stops it, and
// expire_o is high in the cycle the request has been outstanding TO_CYC clocks.
module spi_bus_timer #(
    parameter int unsigned TO_CYC = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(TO_CYC - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       run_q, run_d;

    assign expire_o = run_q && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            cnt_d = '0;
            run_d = 1'b1;
        end else if (clear_i) begin
            cnt_d = '0;
            run_d = 1'b0;
        end else if (run_q && !expire_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Converts spi_data_path header/data pulses into req/ack register-bus beats,
// with address auto-increment, read prefetch, timeout and overrun detection.
module spi_reg_bridge import spi_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TO_CYC = TO_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              address_ready,
    input  logic              data_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        status,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    spi_reg_bridge_if.master  bus,
    output logic              busy,
    output logic [2:0]        err
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] acnt_q, acnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [DATA_W-1:0] bwdata_q, bwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        err_q, err_d;
    logic              tmr_load, tmr_clear, tmr_expire;

    spi_bus_timer #(.TO_CYC(TO_CYC)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (tmr_load),
        .clear_i  (tmr_clear),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        acnt_d    = acnt_q;
        req_d     = req_q;
        we_d      = we_q;
        baddr_d   = baddr_q;
        bwdata_d  = bwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (address_ready) begin
                    acnt_d = addr;
                    err_d  = '0;
                    if (status == CMD_WRITE) begin
                        state_d = ST_WR_WAIT;
                    end else if (status == CMD_READ) begin
                        req_d    = 1'b1;
                        we_d     = 1'b0;
                        baddr_d  = addr;
                        tmr_load = 1'b1;
                        state_d  = ST_RD_REQ;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (data_ready) begin
                    bwdata_d = wdata;
                    baddr_d  = acnt_q;
                    we_d     = 1'b1;
                    req_d    = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_WR_REQ;
                end
            end
            ST_RD_HOLD: begin
                if (cs_n) begin
                    state_d = ST_IDLE;
                end else if (data_ready) begin
                    baddr_d  = acnt_q;
                    we_d     = 1'b0;
                    req_d    = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = ST_RD_REQ;
                end
            end
            ST_WR_REQ, ST_RD_REQ, ST_DRAIN: begin
                // One completion path for both directions; ack beats a same-cycle expiry.
                if (bus.bus_ack || tmr_expire) begin
                    req_d     = 1'b0;
                    tmr_clear = 1'b1;
                    acnt_d    = acnt_q + ADDR_W'(1);
                    if (!bus.bus_ack) begin
                        err_d[1] = 1'b1;
                    end
                    if (!we_q) begin
                        rdata_d = bus.bus_ack ? bus.bus_rdata : DATA_W'(RD_TIMEOUT_PATTERN);
                    end
                    if (state_q == ST_DRAIN) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = we_q ? ST_WR_WAIT : ST_RD_HOLD;
                    end
                end else if (cs_n) begin
                    state_d = ST_DRAIN;
                end
                if (data_ready && (state_q != ST_DRAIN)) begin
                    err_d[2] = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            acnt_q   <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            acnt_q   <= acnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = baddr_q;
    assign bus.bus_wdata = bwdata_q;
    assign rdata         = rdata_q;
    assign err           = err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: a behavioural bus slave logs every
// completed beat; each scenario task compares the log and outputs to expectations.
module tb_spi_reg_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs_n;
    logic        address_ready;
    logic        data_ready;
    logic [19:0] addr;
    logic [3:0]  status;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy;
    logic [2:0]  err;

    spi_reg_bridge_if #(.ADDR_W(20), .DATA_W(16)) bus_if ();

    spi_reg_bridge #(.ADDR_W(20), .DATA_W(16), .TO_CYC(255)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cs_n          (cs_n),
        .address_ready (address_ready),
        .data_ready    (data_ready),
        .addr          (addr),
        .status        (status),
        .wdata         (wdata),
        .rdata         (rdata),
        .bus           (bus_if),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [19:0] a;
        logic [15:0] d;
    } txn_t;

    int          total = 0;
    int          bad   = 0;
    txn_t        log_q[$];
    logic [15:0] rd_vals [0:1023];
    int          rd_count  = 0;
    int          req_rises = 0;
    bit          prev_req  = 1'b0;
    int          wait_cnt  = 0;
    int          ack_delay = 0;
    bit          ack_en    = 1'b1;

    // Bus slave: acks ack_delay cycles after req rises, records each completed beat.
    always begin
        txn_t t;
        @(posedge clk);
        #2;
        if (bus_if.bus_req && !prev_req) req_rises++;
        prev_req = bus_if.bus_req;
        bus_if.bus_rdata = 16'($urandom);
        if (bus_if.bus_req === 1'b1 && reset_n === 1'b1) begin
            if (ack_en && wait_cnt == ack_delay) begin
                bus_if.bus_ack = 1'b1;
                t.we = bus_if.bus_we;
                t.a  = bus_if.bus_addr;
                if (bus_if.bus_we) begin
                    t.d = bus_if.bus_wdata;
                end else begin
                    bus_if.bus_rdata = rd_vals[rd_count];
                    t.d = rd_vals[rd_count];
                    rd_count++;
                end
                log_q.push_back(t);
            end else begin
                bus_if.bus_ack = 1'b0;
            end
            wait_cnt++;
        end else begin
            bus_if.bus_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic send_header(input logic [19:0] a, input logic [3:0] st);
        @(negedge clk);
        addr = a;
        status = st;
        address_ready = 1'b1;
        @(negedge clk);
        address_ready = 1'b0;
        addr = 20'($urandom);
        status = 4'($urandom);
    endtask

    task automatic pulse_data(input logic [15:0] d);
        @(negedge clk);
        wdata = d;
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        wdata = 16'($urandom);
    endtask

    task automatic wait_log(input int n, input int limit);
        int c = 0;
        while (log_q.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (log_q.size() < n) begin
            bad++;
            $display("FAIL wait_log beats=%0d required=%0d", log_q.size(), n);
        end
        @(negedge clk);
    endtask

    task automatic wait_req_low(input int limit);
        int c = 0;
        while (bus_if.bus_req && c < limit) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (bus_if.bus_req !== 1'b0) begin
            bad++;
            $display("FAIL wait_req_low req=%b required=0", bus_if.bus_req);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cs_n = 1'b1;
        address_ready = 1'b0;
        data_ready = 1'b0;
        addr = '0;
        status = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus_if.bus_req); end
        total++; if (bus_if.bus_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus_if.bus_we); end
        total++; if (bus_if.bus_addr !== 20'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus_if.bus_addr); end
        total++; if (bus_if.bus_wdata !== 16'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus_if.bus_wdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL reset_err got=%b exp=000", err); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_burst();
        int base = log_q.size();
        logic [15:0] wd [2];
        wd[0] = 16'h1111;
        wd[1] = 16'h2222;
        ack_en = 1'b1;
        ack_delay = 2;
        cs_n = 1'b0;
        send_header(20'h00010, 4'h1);
        for (int i = 0; i < 2; i++) begin
            pulse_data(wd[i]);
            wait_log(base + i + 1, 40);
            total++; if (log_q[base+i].we !== 1'b1) begin bad++; $display("FAIL wr_we[%0d] got=%b exp=1", i, log_q[base+i].we); end
            total++; if (log_q[base+i].a !== 20'h00010 + 20'(i)) begin bad++; $display("FAIL wr_addr[%0d] got=%h exp=%h", i, log_q[base+i].a, 20'h00010 + 20'(i)); end
            total++; if (log_q[base+i].d !== wd[i]) begin bad++; $display("FAIL wr_data[%0d] got=%h exp=%h", i, log_q[base+i].d, wd[i]); end
        end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL wr_err got=%b exp=000", err); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_read_prefetch();
        int base = log_q.size();
        logic [15:0] third = 16'($urandom);
        rd_vals[rd_count]   = 16'hC69A;
        rd_vals[rd_count+1] = 16'h1234;
        rd_vals[rd_count+2] = third;
        ack_en = 1'b1;
        ack_delay = $urandom_range(0, 4);
        cs_n = 1'b0;
        send_header(20'hFFFFF, 4'h2);
        total++; if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL rd_latency_req got=%b exp=1", bus_if.bus_req); end
        total++; if (bus_if.bus_we !== 1'b0) begin bad++; $display("FAIL rd_we got=%b exp=0", bus_if.bus_we); end
        wait_log(base + 1, 40);
        total++; if (rdata !== 16'hC69A) begin bad++; $display("FAIL rd0_rdata got=%h exp=C69A", rdata); end
        total++; if (log_q[base].a !== 20'hFFFFF) begin bad++; $display("FAIL rd0_addr got=%h exp=FFFFF", log_q[base].a); end
        pulse_data(16'($urandom));
        total++; if (bus_if.bus_addr !== 20'h00000) begin bad++; $display("FAIL rd1_wrap_addr got=%h exp=00000", bus_if.bus_addr); end
        total++; if (rdata !== 16'hC69A) begin bad++; $display("FAIL rd1_hold got=%h exp=C69A", rdata); end
        wait_log(base + 2, 40);
        total++; if (rdata !== 16'h1234) begin bad++; $display("FAIL rd1_rdata got=%h exp=1234", rdata); end
        pulse_data(16'($urandom));
        total++; if (bus_if.bus_addr !== 20'h00001) begin bad++; $display("FAIL rd2_addr got=%h exp=00001", bus_if.bus_addr); end
        wait_log(base + 3, 40);
        total++; if (rdata !== third) begin bad++; $display("FAIL rd2_rdata got=%h exp=%h", rdata, third); end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL rd_err got=%b exp=000", err); end
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_timeout();
        int base = log_q.size();
        int cnt = 0;
        logic [19:0] a = 20'($urandom);
        logic [19:0] na = 20'((int'(a) + 1) % (1 << 20));
        ack_en = 1'b0;
        cs_n = 1'b0;
        send_header(a, 4'h2);
        while (bus_if.bus_req === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        total++; if (cnt !== 255) begin bad++; $display("FAIL to_req_cycles got=%0d exp=255", cnt); end
        total++; if (rdata !== 16'hDEAD) begin bad++; $display("FAIL to_rdata got=%h exp=DEAD", rdata); end
        total++; if (err !== 3'b010) begin bad++; $display("FAIL to_err got=%b exp=010", err); end
        total++; if (log_q.size() !== base) begin bad++; $display("FAIL to_no_beat got=%0d exp=%0d", log_q.size(), base); end
        ack_en = 1'b1;
        ack_delay = 1;
        pulse_data(16'($urandom));
        total++; if (bus_if.bus_addr !== na) begin bad++; $display("FAIL to_next_addr got=%h exp=%h", bus_if.bus_addr, na); end
        wait_log(base + 1, 40);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overrun();
        int base = log_q.size();
        int rises0 = req_rises;
        logic [19:0] a = 20'($urandom);
        logic [15:0] w1 = 16'($urandom);
        ack_en = 1'b1;
        ack_delay = 10;
        cs_n = 1'b0;
        send_header(a, 4'h1);
        pulse_data(w1);
        @(negedge clk);
        pulse_data(~w1);
        wait_log(base + 1, 50);
        repeat (5) @(negedge clk);
        total++; if (log_q.size() !== base + 1) begin bad++; $display("FAIL ovr_beats got=%0d exp=%0d", log_q.size(), base + 1); end
        total++; if (req_rises - rises0 !== 1) begin bad++; $display("FAIL ovr_reqs got=%0d exp=1", req_rises - rises0); end
        total++; if (log_q[base].d !== w1 || log_q[base].a !== a) begin bad++; $display("FAIL ovr_beat got=%h@%h exp=%h@%h", log_q[base].d, log_q[base].a, w1, a); end
        total++; if (err !== 3'b100) begin bad++; $display("FAIL ovr_err got=%b exp=100", err); end
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_illegal_drain();
        int base;
        int rises0 = req_rises;
        logic [19:0] a2 = 20'($urandom);
        logic [15:0] w = 16'($urandom);
        cs_n = 1'b0;
        send_header(20'($urandom), 4'h7);
        repeat (3) @(negedge clk);
        total++; if (err !== 3'b001) begin bad++; $display("FAIL ill_err got=%b exp=001", err); end
        total++; if (req_rises !== rises0) begin bad++; $display("FAIL ill_noreq got=%0d exp=%0d", req_rises, rises0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ill_busy got=%b exp=0", busy); end
        base = log_q.size();
        ack_en = 1'b1;
        ack_delay = 8;
        send_header(a2, 4'h1);
        pulse_data(w);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL drain_req got=%b exp=1", bus_if.bus_req); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy got=%b exp=1", busy); end
        wait_req_low(50);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b exp=0", busy); end
        total++; if (log_q.size() !== base + 1 || log_q[base].a !== a2 || log_q[base].d !== w) begin bad++; $display("FAIL drain_beat got=%h@%h exp=%h@%h", log_q[base].d, log_q[base].a, w, a2); end
        total++; if (err !== 3'b000) begin bad++; $display("FAIL drain_err got=%b exp=000", err); end
    endtask

    task automatic test_reset_mid();
        int base = log_q.size();
        rd_vals[rd_count] = 16'hA5A5;
        ack_en = 1'b1;
        ack_delay = 1;
        cs_n = 1'b0;
        send_header(20'($urandom), 4'h2);
        wait_log(base + 1, 40);
        total++; if (rdata !== 16'hA5A5) begin bad++; $display("FAIL rst_pre_rdata got=%h exp=A5A5", rdata); end
        ack_en = 1'b0;
        pulse_data(16'($urandom));
        pulse_data(16'($urandom));
        total++; if (err !== 3'b100 || bus_if.bus_req !== 1'b1 || rdata !== 16'hA5A5) begin bad++; $display("FAIL rst_pre_state got=err%b req%b rd%h exp=err100 req1 rdA5A5", err, bus_if.bus_req, rdata); end
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus_if.bus_req); end
        total++; if ({rdata, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, busy, err} !== '0) begin bad++; $display("FAIL rst_outputs got=rd%h we%b a%h wd%h busy%b err%b exp=all0", rdata, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, busy, err); end
        reset_n = 1'b1;
        cs_n = 1'b1;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 24; r++) begin
            int base = log_q.size();
            int len = $urandom_range(1, 4);
            bit is_wr = 1'($urandom_range(0, 1));
            logic [19:0] start;
            logic [15:0] exp_d [4];
            if ($urandom_range(0, 3) == 0) start = 20'hFFFFF - 20'($urandom_range(0, 2));
            else start = 20'($urandom);
            ack_en = 1'b1;
            ack_delay = $urandom_range(0, 5);
            cs_n = 1'b0;
            if (is_wr) begin
                send_header(start, 4'h1);
                for (int i = 0; i < len; i++) begin
                    exp_d[i] = 16'($urandom);
                    pulse_data(exp_d[i]);
                    wait_log(base + i + 1, 40);
                end
            end else begin
                for (int i = 0; i < len; i++) begin
                    exp_d[i] = 16'($urandom);
                    rd_vals[rd_count + i] = exp_d[i];
                end
                send_header(start, 4'h2);
                for (int i = 0; i < len; i++) begin
                    if (i > 0) pulse_data(16'($urandom));
                    wait_log(base + i + 1, 40);
                    total++; if (rdata !== exp_d[i]) begin bad++; $display("FAIL b2b_rdata r%0d[%0d] got=%h exp=%h", r, i, rdata, exp_d[i]); end
                end
            end
            for (int i = 0; i < len; i++) begin
                logic [19:0] ea = 20'((int'(start) + i) % (1 << 20));
                total++;
                if (log_q[base+i].we !== is_wr || log_q[base+i].a !== ea || log_q[base+i].d !== exp_d[i]) begin
                    bad++;
                    $display("FAIL b2b_beat r%0d[%0d] got=we%b %h@%h exp=we%b %h@%h", r, i, log_q[base+i].we, log_q[base+i].d, log_q[base+i].a, is_wr, exp_d[i], ea);
                end
            end
            total++; if (err !== 3'b000) begin bad++; $display("FAIL b2b_err r%0d got=%b exp=000", r, err); end
            cs_n = 1'b1;
            repeat (2) @(negedge clk);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy r%0d got=%b exp=0", r, busy); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rd_vals[i] = 16'($urandom);
        test_reset();
        test_write_burst();
        test_read_prefetch();
        test_timeout();
        test_overrun();
        test_illegal_drain();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
